// File: rtl/s713_resp_misr_if.sv
// Response stream between the s713 output capture and the MISR compactor.
// The producer drives valid/data; the compactor answers with ready.
interface s713_resp_misr_if #(
  parameter int W = 23
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/s713_resp_misr.sv
// MISR response compactor for the s713 core: folds one W-bit response per vector
// into a signature over a programmed vector count, then compares it to a golden value.
module s713_resp_misr #(
  parameter int           W    = 23,
  parameter int           CW   = 16,
  parameter logic [W-1:0] POLY = 23'h000021,
  parameter logic [W-1:0] SEED = 23'h000000
) (
  input  logic                CK,
  input  logic                RST_N,
  input  logic                start,
  input  logic [CW-1:0]       num_vec,
  input  logic [W-1:0]        golden,
  s713_resp_misr_if.slave     resp,
  output logic [W-1:0]        sig,
  output logic [CW-1:0]       count,
  output logic                busy,
  output logic                done,
  output logic                pass
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r, state_nx_s;
  logic [W-1:0]  sig_r, sig_nx_s;
  logic [W-1:0]  golden_r, golden_nx_s;
  logic [CW-1:0] count_r, count_nx_s;
  logic [CW-1:0] target_r, target_nx_s;
  logic          ready_r, busy_r, done_r, pass_r;
  logic          ready_nx_s, busy_nx_s, done_nx_s, pass_nx_s;
  logic          take_s, start_ok_s, last_s;

  // Galois step: multiply by x modulo the feedback polynomial, then fold in the response
  function automatic logic [W-1:0] misr_step(input logic [W-1:0] cur, input logic [W-1:0] din);
    logic [W-1:0] shifted;
    shifted = {cur[W-2:0], 1'b0};
    if (cur[W-1]) begin
      shifted = shifted ^ POLY;
    end else begin
      shifted = shifted;
    end
    return shifted ^ din;
  endfunction

  // Handshake qualifiers; ready is a flop, so no path from valid back to ready
  always_comb begin
    take_s     = resp.valid && ready_r;
    start_ok_s = start && (state_r != ST_RUN);
    last_s     = (count_r + CW'(1)) == target_r;
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_ok_s) begin
          state_nx_s = (num_vec == {CW{1'b0}}) ? ST_DONE : ST_RUN;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_RUN: begin
        if (take_s && last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Datapath next values: a start reloads the run context, a taken beat advances the MISR
  always_comb begin
    sig_nx_s    = sig_r;
    count_nx_s  = count_r;
    target_nx_s = target_r;
    golden_nx_s = golden_r;
    if (start_ok_s) begin
      sig_nx_s    = SEED;
      count_nx_s  = {CW{1'b0}};
      target_nx_s = num_vec;
      golden_nx_s = golden;
    end else if (take_s) begin
      sig_nx_s   = misr_step(sig_r, resp.data);
      count_nx_s = count_r + CW'(1);
    end else begin
      sig_nx_s   = sig_r;
      count_nx_s = count_r;
    end
  end

  // Output decode of the upcoming state, registered below so every output is a flop
  always_comb begin
    ready_nx_s = (state_nx_s == ST_RUN);
    busy_nx_s  = (state_nx_s == ST_RUN);
    done_nx_s  = (state_nx_s == ST_DONE);
    pass_nx_s  = done_nx_s && (sig_nx_s == golden_nx_s);
  end

  // State and status registers
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      ready_r <= ready_nx_s;
      busy_r  <= busy_nx_s;
      done_r  <= done_nx_s;
      pass_r  <= pass_nx_s;
    end
  end

  // Signature, counter and per-run context registers
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      sig_r    <= {W{1'b0}};
      count_r  <= {CW{1'b0}};
      target_r <= {CW{1'b0}};
      golden_r <= {W{1'b0}};
    end else begin
      sig_r    <= sig_nx_s;
      count_r  <= count_nx_s;
      target_r <= target_nx_s;
      golden_r <= golden_nx_s;
    end
  end

  assign resp.ready = ready_r;
  assign sig        = sig_r;
  assign count      = count_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;

endmodule

// File: tb/tb_s713_resp_misr.sv
// Randomized bench for s713_resp_misr against a polynomial-arithmetic signature model.
module tb_s713_resp_misr;

  logic        CK = 1'b0;
  logic        RST_N;
  logic        start;
  logic [15:0] num_vec;
  logic [22:0] golden;
  logic [22:0] sig;
  logic [15:0] count;
  logic        busy, done, pass;

  int n_cmp = 0;
  int n_bad = 0;
  logic [22:0] vecs [0:31];

  s713_resp_misr_if #(.W(23)) rif ();

  s713_resp_misr dut (
    .CK(CK), .RST_N(RST_N), .start(start), .num_vec(num_vec), .golden(golden),
    .resp(rif), .sig(sig), .count(count), .busy(busy), .done(done), .pass(pass)
  );

  always #5 CK = ~CK;

  // Signature = previous signature times x, reduced modulo x^23+x^5+1, plus the response
  function automatic logic [22:0] model_step(input logic [22:0] s, input logic [22:0] d);
    logic [23:0] t;
    t = {s, 1'b0};
    if (t[23]) t = t ^ 24'h800021;
    return t[22:0] ^ d;
  endfunction

  function automatic logic [22:0] model_sig(input int nv);
    logic [22:0] m;
    m = 23'h000000;
    for (int i = 0; i < nv; i++) m = model_step(m, vecs[i]);
    return m;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic do_run(input int nv, input logic [22:0] gd, input int stall_lo, input int stall_hi);
    logic [22:0] m;
    int k;
    m = 23'h000000;
    start = 1'b1; num_vec = 16'(nv); golden = gd;
    tick();
    start = 1'b0; num_vec = 16'($urandom); golden = 23'($urandom);
    if (nv == 0) begin
      check_val("zero_done", done, 1);
      check_val("zero_busy", busy, 0);
      check_val("zero_sig", sig, 0);
      check_val("zero_count", count, 0);
      check_val("zero_pass", pass, (gd == 23'h0) ? 1 : 0);
    end else begin
      check_val("run_busy", busy, 1);
      check_val("run_sig0", sig, 0);
      check_val("run_count0", count, 0);
      for (int i = 0; i < nv; i++) begin
        k = $urandom_range(stall_hi, stall_lo);
        for (int j = 0; j < k; j++) begin
          rif.valid = 1'b0; rif.data = 23'($urandom);
          start = 1'($urandom_range(1, 0)); num_vec = 16'($urandom_range(3, 0));
          tick();
          start = 1'b0;
          check_val("stall_sig", sig, m);
          check_val("stall_count", count, i);
        end
        check_val("ready_run", rif.ready, 1);
        rif.valid = 1'b1; rif.data = vecs[i];
        tick();
        m = model_step(m, vecs[i]);
        check_val("beat_sig", sig, m);
        check_val("beat_count", count, i + 1);
        check_val("beat_done", done, (i == nv - 1) ? 1 : 0);
      end
      rif.valid = 1'b0;
      check_val("end_ready", rif.ready, 0);
      check_val("end_busy", busy, 0);
      check_val("end_pass", pass, (m == gd) ? 1 : 0);
      rif.valid = 1'b1; rif.data = 23'($urandom);
      tick();
      rif.valid = 1'b0;
      check_val("hold_sig", sig, m);
      check_val("hold_count", count, nv);
      check_val("hold_done", done, 1);
      check_val("hold_pass", pass, (m == gd) ? 1 : 0);
    end
  endtask

  initial begin
    logic [22:0] gexp;
    int nv;
    RST_N = 1'b0; start = 1'b0; num_vec = 16'h0; golden = 23'h0;
    rif.valid = 1'b0; rif.data = 23'h0;
    tick(); tick();
    RST_N = 1'b1;
    check_val("rst_ready", rif.ready, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_pass", pass, 0);
    check_val("rst_sig", sig, 0);
    check_val("rst_count", count, 0);

    vecs[0] = 23'h000001;
    do_run(1, 23'h000001, 0, 0);
    check_val("t1_sig", sig, 23'h000001);

    vecs[0] = 23'h400000; vecs[1] = 23'h000000;
    do_run(2, 23'h000021, 0, 0);
    check_val("t2_sig", sig, 23'h000021);
    check_val("t2_pass", pass, 1);
    do_run(2, 23'h000022, 0, 0);
    check_val("t3_pass", pass, 0);
    check_val("t3_sig", sig, 23'h000021);
    do_run(2, 23'h000021, 5, 5);
    check_val("t4_sig", sig, 23'h000021);
    check_val("t4_count", count, 2);
    do_run(0, 23'h000000, 0, 0);
    do_run(0, 23'h000005, 0, 0);

    // Mid-run reset discards the partial signature
    for (int i = 0; i < 4; i++) vecs[i] = 23'($urandom);
    start = 1'b1; num_vec = 16'd4; golden = 23'h0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rif.valid = 1'b1; rif.data = vecs[i];
      tick();
    end
    rif.valid = 1'b0;
    start = 1'b1; num_vec = 16'd1;
    tick();
    start = 1'b0;
    check_val("t6_ign_count", count, 2);
    check_val("t6_ign_busy", busy, 1);
    check_val("t6_ign_sig", sig, model_sig(2));
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    check_val("t6_busy", busy, 0);
    check_val("t6_done", done, 0);
    check_val("t6_ready", rif.ready, 0);
    check_val("t6_sig", sig, 0);
    check_val("t6_count", count, 0);

    for (int r = 0; r < 30; r++) begin
      nv = $urandom_range(12, 0);
      for (int i = 0; i < nv; i++) vecs[i] = 23'($urandom);
      gexp = model_sig(nv);
      if ($urandom_range(1, 0) == 0) gexp = gexp ^ (23'h1 << $urandom_range(22, 0));
      do_run(nv, gexp, 0, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
